div_cdb_buffer: RTL and testbench

DIV_CDB_BUFFER -- requirements
Module: div_cdb_buffer

---
 rtl/div_cdb_buffer_pkg.sv | 23 ++
 rtl/div_cdb_buffer_if.sv | 21 ++
 rtl/div_cdb_buffer_sync_fifo_ptr.sv | 45 ++++
 rtl/div_cdb_buffer.sv | 73 +++++++
 tb/tb_div_cdb_buffer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/div_cdb_buffer_pkg.sv
// Shared RV32I pipeline types: CDB broadcast payload and divide RS output.
package rv32i_types;
    localparam int CDB_NO_PHY_REGS   = 64;
    localparam int CDB_PHY_WIDTH     = $clog2(CDB_NO_PHY_REGS);
    localparam int CDB_ROB_IDX_WIDTH = 5;

    typedef struct packed {
        logic [CDB_PHY_WIDTH-1:0]     pd;
        logic [4:0]                   rd;
        logic [CDB_ROB_IDX_WIDTH-1:0] rob_idx;
        logic [31:0]                  data;
    } cdb_entry_t;

    typedef struct packed {
        logic                         valid;
        logic [31:0]                  rs1_v;
        logic [31:0]                  rs2_v;
        logic [2:0]                   funct3;
        logic [CDB_PHY_WIDTH-1:0]     pd;
        logic [4:0]                   rd;
        logic [CDB_ROB_IDX_WIDTH-1:0] rob_idx;
    } res_station_div_out_s;
endpackage

// File: rtl/div_cdb_buffer_if.sv
// Divider-side handshakes: issue credit, result push, CDB request/grant, squash.
interface div_cdb_buffer_if import rv32i_types::*; ();
    logic       flush;
    logic       issue_valid;
    logic       issue_ready;
    logic       res_valid;
    cdb_entry_t res_entry;
    logic       cdb_req;
    cdb_entry_t cdb_entry;
    logic       cdb_grant;

    modport master (
        output flush, issue_valid, res_valid, res_entry, cdb_grant,
        input  issue_ready, cdb_req, cdb_entry
    );

    modport slave (
        input  flush, issue_valid, res_valid, res_entry, cdb_grant,
        output issue_ready, cdb_req, cdb_entry
    );
endinterface

// File: rtl/div_cdb_buffer_sync_fifo_ptr.sv
// Circular result store with wrapping pointers; reads as zero while empty.
module sync_fifo_ptr #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr, rptr;
    logic             do_pop;

    assign do_pop = pop && (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)   wptr <= wptr + PW'(1);
            if (do_pop) rptr <= rptr + PW'(1);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; empty reads are masked below.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wptr] <= push_data;
    end

    assign head_data = (count != '0) ? mem[rptr] : '0;
endmodule

// File: rtl/div_cdb_buffer.sv
// Non-stalling divider result buffer: credit admission, CDB request, flush drop.
module div_cdb_buffer import rv32i_types::*; #(
    parameter int DEPTH         = 4,
    parameter int NO_PHY_REGS   = 64,
    parameter int PHY_WIDTH     = $clog2(NO_PHY_REGS),
    parameter int ROB_IDX_WIDTH = 5
) (
    input logic             clk,
    input logic             rst_n,
    div_cdb_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if (PHY_WIDTH != CDB_PHY_WIDTH || ROB_IDX_WIDTH != CDB_ROB_IDX_WIDTH) begin : g_bad_width
        $error("div_cdb_buffer widths disagree with rv32i_types");
    end
    if (DEPTH < 2 || (1 << PW) != DEPTH) begin : g_bad_depth
        $error("div_cdb_buffer DEPTH must be a power of 2, at least 2");
    end

    logic [CW-1:0] count, inflight, drop_cnt, drop_next;
    logic [CW:0]   occ;
    logic          push, pop;
    cdb_entry_t    head;

    assign push = bus.res_valid && (drop_cnt == '0) && !bus.flush;
    assign pop  = bus.cdb_grant && !bus.flush;

    sync_fifo_ptr #(.DEPTH(DEPTH), .WIDTH($bits(cdb_entry_t))) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (bus.flush),
        .push      (push),
        .push_data (bus.res_entry),
        .pop       (pop),
        .head_data (head),
        .count     (count)
    );

    assign bus.cdb_req   = (count != '0);
    assign bus.cdb_entry = head;

    // Credit check uses registered state only, so no input reaches issue_ready.
    assign occ             = {1'b0, count} + {1'b0, inflight};
    assign bus.issue_ready = (occ < (CW+1)'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else if (bus.issue_valid && !bus.res_valid) begin
            inflight <= inflight + CW'(1);
        end else if (!bus.issue_valid && bus.res_valid && inflight != '0) begin
            inflight <= inflight - CW'(1);
        end
    end

    // Everything still in the divider at the squash is older and must be dropped.
    always_comb begin
        drop_next = inflight + CW'(bus.issue_valid);
        if (bus.res_valid && drop_next != '0) drop_next = drop_next - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (bus.flush) begin
            drop_cnt <= drop_next;
        end else if (bus.res_valid && drop_cnt != '0) begin
            drop_cnt <= drop_cnt - CW'(1);
        end
    end
endmodule

// File: tb/tb_div_cdb_buffer.sv
// Directed bench for div_cdb_buffer with hand-computed expectations.
module tb_div_cdb_buffer;
    import rv32i_types::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    div_cdb_buffer_if bus ();

    div_cdb_buffer #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic cdb_entry_t mk(input logic [31:0] d);
        cdb_entry_t e;
        e.pd      = d[5:0];
        e.rd      = d[4:0];
        e.rob_idx = d[7:3];
        e.data    = d;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(bus.issue_valid && !bus.issue_ready)) else begin
                miscompares++;
                $error("FAIL protocol: issue_valid observed 1 while issue_ready 0, required 0");
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.flush = 0; bus.issue_valid = 0; bus.res_valid = 0;
        bus.res_entry = '0; bus.cdb_grant = 0;

        // reset state
        #1 rst_n = 0;
        #2;
        chk("rst_cdb_req", 64'(bus.cdb_req), 64'd0);
        chk("rst_cdb_entry", 64'(bus.cdb_entry), 64'd0);
        chk("rst_issue_ready", 64'(bus.issue_ready), 64'd1);
        chk("rst_count", 64'(dut.count), 64'd0);
        chk("rst_inflight", 64'(dut.inflight), 64'd0);
        chk("rst_drop_cnt", 64'(dut.drop_cnt), 64'd0);
        tick; tick;
        rst_n = 1;
        tick;

        // back-to-back issue, grant low
        bus.issue_valid = 1; tick;
        chk("b2b_inflight1", 64'(dut.inflight), 64'd1);
        chk("b2b_ready1", 64'(bus.issue_ready), 64'd1);
        bus.res_valid = 1; bus.res_entry = mk(32'h11);
        #1 chk("no_bypass", 64'(bus.cdb_req), 64'd0);
        tick;
        chk("b2b_count1", 64'(dut.count), 64'd1);
        chk("b2b_req1", 64'(bus.cdb_req), 64'd1);
        bus.res_entry = mk(32'h22); tick;
        chk("b2b_count2", 64'(dut.count), 64'd2);
        chk("b2b_ready3", 64'(bus.issue_ready), 64'd1);
        bus.res_entry = mk(32'h33); tick;
        chk("b2b_ready_after4", 64'(bus.issue_ready), 64'd0);
        chk("b2b_count3", 64'(dut.count), 64'd3);
        bus.issue_valid = 0; bus.res_entry = mk(32'h44); tick;
        bus.res_valid = 0;
        chk("b2b_count4", 64'(dut.count), 64'd4);
        chk("b2b_inflight0", 64'(dut.inflight), 64'd0);
        chk("b2b_ready_full", 64'(bus.issue_ready), 64'd0);
        chk("b2b_head_entry", 64'(bus.cdb_entry), 64'(mk(32'h11)));

        // drain with steady grant
        bus.cdb_grant = 1;
        chk("drain_0", 64'(bus.cdb_entry.data), 64'h11);
        tick; chk("drain_1", 64'(bus.cdb_entry.data), 64'h22);
        tick; chk("drain_2", 64'(bus.cdb_entry.data), 64'h33);
        tick; chk("drain_3", 64'(bus.cdb_entry.data), 64'h44);
        tick;
        chk("drain_req0", 64'(bus.cdb_req), 64'd0);
        chk("drain_entry0", 64'(bus.cdb_entry), 64'd0);
        tick;
        chk("grant_empty_count", 64'(dut.count), 64'd0);
        chk("grant_empty_ready", 64'(bus.issue_ready), 64'd1);
        bus.cdb_grant = 0;

        // refill, then push and pop together at full
        for (int i = 0; i < 5; i++) begin
            bus.issue_valid = (i < 4);
            bus.res_valid   = (i > 0);
            bus.res_entry   = mk(32'hA0 + 32'(i));
            tick;
        end
        bus.issue_valid = 0; bus.res_valid = 0;
        chk("full_count", 64'(dut.count), 64'd4);
        chk("full_head", 64'(bus.cdb_entry.data), 64'hA1);
        bus.res_valid = 1; bus.res_entry = mk(32'hB5); bus.cdb_grant = 1;
        tick;
        bus.res_valid = 0;
        chk("pp_full_count", 64'(dut.count), 64'd4);
        chk("pp_full_head", 64'(bus.cdb_entry.data), 64'hA2);
        tick; chk("pp_drain_a3", 64'(bus.cdb_entry.data), 64'hA3);
        tick; chk("pp_drain_a4", 64'(bus.cdb_entry.data), 64'hA4);
        tick; chk("pp_wrapped_tail", 64'(bus.cdb_entry), 64'(mk(32'hB5)));
        tick; chk("pp_empty", 64'(bus.cdb_req), 64'd0);
        bus.cdb_grant = 0;

        // flush with one op issued in the flush cycle
        bus.issue_valid = 1; bus.flush = 1; tick;
        chk("fl_drop1", 64'(dut.drop_cnt), 64'd1);
        chk("fl_inflight1", 64'(dut.inflight), 64'd1);
        bus.issue_valid = 0; bus.flush = 0;
        bus.res_valid = 1; bus.res_entry = mk(32'h55); tick;
        bus.res_valid = 0;
        chk("fl_drop0", 64'(dut.drop_cnt), 64'd0);
        chk("fl_count0", 64'(dut.count), 64'd0);
        chk("fl_inflight0", 64'(dut.inflight), 64'd0);
        tick;
        chk("fl_req0", 64'(bus.cdb_req), 64'd0);

        // flush with buffered entry, pop in flush cycle, young post-flush op
        bus.issue_valid = 1; tick;
        bus.res_valid = 1; bus.res_entry = mk(32'h66); tick;
        chk("yf_count1", 64'(dut.count), 64'd1);
        chk("yf_inflight1", 64'(dut.inflight), 64'd1);
        bus.issue_valid = 0; bus.res_valid = 0; bus.flush = 1; bus.cdb_grant = 1; tick;
        chk("yf_req0", 64'(bus.cdb_req), 64'd0);
        chk("yf_drop1", 64'(dut.drop_cnt), 64'd1);
        bus.flush = 0; bus.cdb_grant = 0;
        bus.issue_valid = 1; bus.res_valid = 1; bus.res_entry = mk(32'h77); tick;
        chk("yf_old_dropped", 64'(dut.count), 64'd0);
        chk("yf_drop0", 64'(dut.drop_cnt), 64'd0);
        bus.issue_valid = 0; bus.res_entry = mk(32'h88); tick;
        bus.res_valid = 0;
        chk("yf_young_kept", 64'(dut.count), 64'd1);
        chk("yf_young_payload", 64'(bus.cdb_entry), 64'(mk(32'h88)));
        bus.cdb_grant = 1; tick; bus.cdb_grant = 0;
        chk("yf_popped", 64'(bus.cdb_req), 64'd0);

        // result arriving in the flush cycle is discarded and not re-counted
        bus.issue_valid = 1; tick;
        bus.issue_valid = 0; bus.flush = 1; bus.res_valid = 1; bus.res_entry = mk(32'h99); tick;
        bus.flush = 0; bus.res_valid = 0;
        chk("frv_drop0", 64'(dut.drop_cnt), 64'd0);
        chk("frv_req0", 64'(bus.cdb_req), 64'd0);
        chk("frv_inflight0", 64'(dut.inflight), 64'd0);

        // async reset mid-cycle with three entries held
        bus.issue_valid = 1; tick;
        bus.res_valid = 1; bus.res_entry = mk(32'hC1); tick;
        bus.res_entry = mk(32'hC2); tick;
        bus.issue_valid = 0; bus.res_entry = mk(32'hC3); tick;
        bus.res_valid = 0;
        chk("ar_count3", 64'(dut.count), 64'd3);
        #2 rst_n = 0;
        #1;
        chk("ar_req0", 64'(bus.cdb_req), 64'd0);
        chk("ar_ready1", 64'(bus.issue_ready), 64'd1);
        chk("ar_count0", 64'(dut.count), 64'd0);
        chk("ar_entry0", 64'(bus.cdb_entry), 64'd0);
        tick;
        rst_n = 1;
        tick;
        chk("ar_post_req0", 64'(bus.cdb_req), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
